// File: rtl/minesweeper_pkg.sv
// ============================================================================
// minesweeper_pkg : shared state encoding, LFSR constants, coordinate widths
// Revision: 1.0
// ============================================================================
`default_nettype none

package minesweeper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_PLACE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int x_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic int y_width(input int height);
    return (height <= 2) ? 1 : $clog2(height);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16 : 16-bit right-shifting Galois LFSR with step enable and seed load
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr16
  import minesweeper_pkg::*;
#(
  parameter logic [15:0] RESET_VALUE = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value,
  output logic [15:0] next_value
);

  // The next value is exposed so the caller can sample the post-step state
  // on the same edge the register advances.
  assign next_value = {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= RESET_VALUE;
    end else if (load) begin
      value <= seed;
    end else if (en) begin
      value <= next_value;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mine_placer.sv
// ============================================================================
// mine_placer : places MINE_COUNT distinct mines on the Board pair via LFSR
//               candidates; SAFE_START_EN keeps a 3x3 area around safeX/safeY free
// Revision: 1.0
// ============================================================================
`default_nettype none

module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          HEIGHT     = 8,
  parameter int          MINE_COUNT = 10,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  localparam int         XW         = x_width(WIDTH),
  localparam int         YW         = y_width(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] safeX,
  input  logic [YW-1:0] safeY,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] readX,
  output logic [YW-1:0] readY,
  input  logic          readValue,
  output logic          writeEn,
  output logic          writeValue,
  output logic          incAdjacent,
  output logic [XW-1:0] writeX,
  output logic [YW-1:0] writeY
);

  localparam int          CW       = $clog2(WIDTH * HEIGHT + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
`ifdef SAFE_START_EN
  localparam int          MAX_MINES = WIDTH * HEIGHT - 9;
`else
  localparam int          MAX_MINES = WIDTH * HEIGHT;
`endif
  localparam logic [XW:0] WIDTH_L  = (XW + 1)'(WIDTH);
  localparam logic [YW:0] HEIGHT_L = (YW + 1)'(HEIGHT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MINE_COUNT);

  generate
    if (WIDTH < 2 || WIDTH > 16 || HEIGHT < 2 || HEIGHT > 16 ||
        MINE_COUNT < 1 || MINE_COUNT >= MAX_MINES) begin : g_param_check
      $error("mine_placer: illegal WIDTH/HEIGHT/MINE_COUNT combination");
    end
  endgenerate

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   count_inc;
  logic [XW-1:0]   cand_x;
  logic [YW-1:0]   cand_y;
  logic            lfsr_en;
  logic [15:0]     lfsr_value;
  logic [15:0]     lfsr_next;
  logic            out_of_range;
  logic            in_safe;
  logic            reject;
  logic            unused_lfsr;

  lfsr16 #(
    .RESET_VALUE (SEED_EFF)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .en         (lfsr_en),
    .load       (1'b0),
    .seed       (SEED_EFF),
    .value      (lfsr_value),
    .next_value (lfsr_next)
  );

  assign unused_lfsr = ^{lfsr_value, lfsr_next};

  assign out_of_range = ({1'b0, cand_x} >= WIDTH_L) || ({1'b0, cand_y} >= HEIGHT_L);

`ifdef SAFE_START_EN
  logic [XW:0] dist_x;
  logic [YW:0] dist_y;

  always_comb begin
    dist_x = (cand_x >= safeX) ? ({1'b0, cand_x} - {1'b0, safeX})
                               : ({1'b0, safeX} - {1'b0, cand_x});
    dist_y = (cand_y >= safeY) ? ({1'b0, cand_y} - {1'b0, safeY})
                               : ({1'b0, safeY} - {1'b0, cand_y});
  end

  assign in_safe = (dist_x <= (XW + 1)'(1)) && (dist_y <= (YW + 1)'(1));
`else
  logic unused_safe;

  assign unused_safe = ^{safeX, safeY};
  assign in_safe     = 1'b0;
`endif

  assign reject    = out_of_range || readValue || in_safe;
  assign count_inc = count + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      cand_x <= '0;
      cand_y <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      // Candidate comes from the post-step LFSR value.
      if (state == ST_GEN) begin
        cand_x <= lfsr_next[XW-1:0];
        cand_y <= lfsr_next[XW+YW-1:XW];
      end
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    lfsr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_GEN;
          count_next = '0;
        end
      end
      ST_GEN: begin
        lfsr_en    = 1'b1;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        state_next = reject ? ST_GEN : ST_PLACE;
      end
      ST_PLACE: begin
        count_next = count_inc;
        state_next = (count_inc == LAST_COUNT) ? ST_DONE : ST_GEN;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  assign busy        = (state == ST_GEN) || (state == ST_CHECK) || (state == ST_PLACE);
  assign done        = (state == ST_DONE);
  assign writeEn     = (state == ST_PLACE);
  assign writeValue  = writeEn;
  assign incAdjacent = writeEn;
  assign readX       = cand_x;
  assign readY       = cand_y;
  assign writeX      = cand_x;
  assign writeY      = cand_y;

endmodule

`default_nettype wire

// File: tb/tb_mine_placer.sv
// ============================================================================
// tb_mine_placer : scoreboard bench for mine_placer with behavioural Board pair
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mine_placer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int MC_A = 10;
`ifdef SAFE_START_EN
  localparam int MC_B = 20;
`else
  localparam int MC_B = 29;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0;
  logic [2:0] sxa = 3'd0, sya = 3'd6, sxb = 3'd0, syb = 3'd0;
  logic busy_a, done_a, we_a, wv_a, ia_a, rv_a;
  logic busy_b, done_b, we_b, wv_b, ia_b, rv_b;
  logic [2:0] rx_a, ry_a, wx_a, wy_a, rx_b, ry_b, wx_b, wy_b;

  bit mine [2][16][16];
  int adj  [2][16][16];
  logic [15:0] mlfsr [2];
  int exp_q[$];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int first_w = -1;

  assign rv_a = mine[0][ry_a][rx_a];
  assign rv_b = mine[1][ry_b][rx_b];

  mine_placer #(.WIDTH(8), .HEIGHT(8), .MINE_COUNT(MC_A), .SEED(SEED)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .safeX(sxa), .safeY(sya),
    .busy(busy_a), .done(done_a), .readX(rx_a), .readY(ry_a), .readValue(rv_a),
    .writeEn(we_a), .writeValue(wv_a), .incAdjacent(ia_a), .writeX(wx_a), .writeY(wy_a));

  mine_placer #(.WIDTH(6), .HEIGHT(5), .MINE_COUNT(MC_B), .SEED(SEED)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .safeX(sxb), .safeY(syb),
    .busy(busy_b), .done(done_b), .readX(rx_b), .readY(ry_b), .readValue(rv_b),
    .writeEn(we_b), .writeValue(wv_b), .incAdjacent(ia_b), .writeX(wx_b), .writeY(wy_b));

  function automatic int dim_w(input int d); return (d == 0) ? 8 : 6; endfunction
  function automatic int dim_h(input int d); return (d == 0) ? 8 : 5; endfunction
  function automatic logic bz(input int d); return (d == 0) ? busy_a : busy_b; endfunction
  function automatic logic dn(input int d); return (d == 0) ? done_a : done_b; endfunction
  function automatic logic we(input int d); return (d == 0) ? we_a : we_b; endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural Board pair: 1-bit mine board and 4-bit adjacency board.
  task automatic board_write(input int d, input int x, input int y, input logic v, input logic inc);
    if (v) mine[d][y][x] = 1'b1;
    if (inc) begin
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < dim_w(d) &&
              y + dy >= 0 && y + dy < dim_h(d))
            adj[d][y+dy][x+dx] = (adj[d][y+dy][x+dx] + 1) % 16;
        end
      end
    end
  endtask

  task automatic board_clear(input int d);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        mine[d][y][x] = 1'b0;
        adj[d][y][x]  = 0;
      end
  endtask

  function automatic int board_sum(input int d);
    int s = 0;
    for (int y = 0; y < dim_h(d); y++)
      for (int x = 0; x < dim_w(d); x++)
        s += int'(mine[d][y][x]);
    return s;
  endfunction

  function automatic int adj_bad(input int d);
    int nb = 0;
    for (int y = 0; y < dim_h(d); y++)
      for (int x = 0; x < dim_w(d); x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < dim_w(d) &&
                y + dy >= 0 && y + dy < dim_h(d))
              n += int'(mine[d][y+dy][x+dx]);
        if (adj[d][y][x] != n) nb++;
      end
    return nb;
  endfunction

  always @(posedge clk) begin
    if (we_a) board_write(0, int'(wx_a), int'(wy_a), wv_a, ia_a);
    if (we_b) board_write(1, int'(wx_b), int'(wy_b), wv_b, ia_b);
  end

  task automatic check_write(input int d, input int x, input int y, input logic v, input logic inc);
    int got = (d << 8) | (x << 4) | y;
    if (wr_cnt == 0) first_w = got;
    wr_cnt++;
    if (exp_q.size() == 0) check("unexpected_write", got, -1);
    else check("write_cell", got, exp_q.pop_front());
    check("write_strobes", int'({v, inc}), 3);
  endtask

  always @(negedge clk) begin
    if (we_a) check_write(0, int'(wx_a), int'(wy_a), wv_a, ia_a);
    if (we_b) check_write(1, int'(wx_b), int'(wy_b), wv_b, ia_b);
  end

  // Reference placement: replay the LFSR against a shadow of the mine board.
  task automatic plan(input int d, input int mc, output int rej);
    bit sh [16][16];
    int placed, cx, cy, sx, sy;
    bit ok;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        sh[y][x] = mine[d][y][x];
    sx = (d == 0) ? int'(sxa) : int'(sxb);
    sy = (d == 0) ? int'(sya) : int'(syb);
    rej = 0;
    placed = 0;
    while (placed < mc) begin
      mlfsr[d] = lfsr_step(mlfsr[d]);
      cx = int'(mlfsr[d] & 16'h0007);
      cy = int'((mlfsr[d] >> 3) & 16'h0007);
      ok = (cx < dim_w(d)) && (cy < dim_h(d)) && !sh[cy][cx];
`ifdef SAFE_START_EN
      if (cx - sx <= 1 && sx - cx <= 1 && cy - sy <= 1 && sy - cy <= 1) ok = 1'b0;
`endif
      if (ok) begin
        sh[cy][cx] = 1'b1;
        exp_q.push_back((d << 8) | (cx << 4) | cy);
        placed++;
      end else begin
        rej++;
      end
    end
    sx = sy;
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start_a = v; else start_b = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mlfsr[0] = SEED;
    mlfsr[1] = SEED;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int d, input int mc, input int budget, input bit restart);
    int rej, sum0, busy_cycles, i;
    logic prev_we;
    sum0 = board_sum(d);
    plan(d, mc, rej);
    wr_cnt = 0;
    first_w = -1;
    @(negedge clk);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    check("busy_after_start", int'(bz(d)), 1);
    busy_cycles = 0;
    prev_we = 1'b0;
    i = 0;
    while (!dn(d) && i < budget) begin
      if (bz(d)) busy_cycles++;
      prev_we = we(d);
      if (restart && i == 4) set_start(d, 1'b1);
      if (restart && i == 5) set_start(d, 1'b0);
      @(negedge clk);
      i++;
    end
    check("done_seen", int'(dn(d)), 1);
    check("busy_cycles", busy_cycles, 3 * mc + 2 * rej);
    check("done_after_last_write", int'(prev_we), 1);
    @(negedge clk);
    check("idle_after_done", int'({bz(d), dn(d)}), 0);
    check("write_count", wr_cnt, mc);
    check("queue_empty", exp_q.size(), 0);
    check("mine_sum", board_sum(d), sum0 + mc);
    check("adjacency_bad_cells", adj_bad(d), 0);
  endtask

  initial begin
    int n, i, zone;
    mlfsr[0] = SEED;
    mlfsr[1] = SEED;

    // T1: outputs while reset is held, then no activity without start
    #12;
    check("reset_outputs_a", int'({busy_a, done_a, we_a, wv_a, ia_a, rx_a, ry_a, wx_a, wy_a}), 0);
    check("reset_outputs_b", int'({busy_b, done_b, we_b, wv_b, ia_b, rx_b, ry_b, wx_b, wy_b}), 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (we_a || we_b || busy_a || busy_b) n++;
    end
    check("idle_without_start", n, 0);

    // T2: basic 8x8 run
    board_clear(0);
    run(0, MC_A, 2000, 1'b0);
`ifdef SAFE_START_EN
    zone = 0;
    for (int y = 5; y <= 7; y++)
      for (int x = 0; x <= 1; x++)
        zone += int'(mine[0][y][x]);
    check("safe_zone_mines", zone, 0);
    check("safe_cell_adjacency", adj[0][6][0], 0);
`else
    check("first_mine_cell", first_w, 6);
`endif

    // T3: first candidate already holds a mine
    do_reset();
    board_clear(0);
    board_write(0, 0, 6, 1'b1, 1'b1);
    run(0, MC_A, 2000, 1'b0);
    check("preloaded_not_rewritten", int'(first_w == 6), 0);

    // T4: non power-of-two board, nearly full
    board_clear(1);
    run(1, MC_B, 20000, 1'b0);

    // T5: start while busy is ignored
    board_clear(0);
    run(0, MC_A, 2000, 1'b1);

    // T5: asynchronous abort during the third placement
    board_clear(0);
    plan(0, MC_A, i);
    wr_cnt = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    i = 0;
    while (n < 3 && i < 2000) begin
      @(negedge clk);
      if (we_a) n++;
      i++;
    end
    check("abort_point_reached", n, 3);
    #2;
    reset = 1'b0;
    #1;
    check("abort_async_drop", int'({we_a, busy_a}), 0);
    @(negedge clk);
    check("abort_no_partial_write", board_sum(0), 2);
    exp_q.delete();
    mlfsr[0] = SEED;
    mlfsr[1] = SEED;
    @(negedge clk);
    reset = 1'b1;
    board_clear(0);
    run(0, MC_A, 2000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
